// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC, 2-entry fetch buffer, RUN/HALT FSM, redirect flush.
// Optional macro FETCH_PERF_CNT_EN adds a 32-bit fetch_count output of accepted pops.
module fetch_ctrl #(
    parameter int unsigned N        = 32,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic         clk,
    input  logic         reset,
    output logic [5:0]   imem_addr,
    input  logic [N-1:0] imem_q,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [N-1:0] instr_out,
    output logic [63:0]  instr_pc,
    output logic         halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]  fetch_count
`endif
);

    localparam int unsigned PCW = 64;
    localparam int unsigned CW  = 2;
    localparam logic [N-1:0] HALT_WORD = N'(32'hb400001f);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t          state, next_state;
    logic [PCW-1:0]  pc;
    logic [CW-1:0]   count;
    logic [N-1:0]    head_word, tail_word;
    logic [PCW-1:0]  head_pc, tail_pc;
    logic            push, pop;

    assign imem_addr   = pc[7:2];
    assign instr_valid = (count != CW'(0));
    assign instr_out   = head_word;
    assign instr_pc    = head_pc;
    assign halted      = (state == HALT);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= next_state;
    end

    // Next state and buffer handshakes; redirect suppresses both push and pop
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        push       = 1'b0;
        if (redirect_valid) begin
            next_state = RUN;
        end else begin
            pop  = instr_valid && instr_ready;
            push = (state == RUN) && ((count != CW'(2)) || pop);
            if (push && (imem_q == HALT_WORD)) next_state = HALT;
        end
    end

    // PC and fetch buffer; head only moves on a pop so outputs hold while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            pc        <= RESET_PC;
            count     <= CW'(0);
            head_word <= '0;
            head_pc   <= '0;
            tail_word <= '0;
            tail_pc   <= '0;
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[63:2], 2'b00};
            count <= CW'(0);
        end else begin
            if (push) pc <= pc + PCW'(4);
            case ({push, pop})
                2'b11: begin
                    if (count == CW'(1)) begin
                        head_word <= imem_q;
                        head_pc   <= pc;
                    end else begin
                        head_word <= tail_word;
                        head_pc   <= tail_pc;
                        tail_word <= imem_q;
                        tail_pc   <= pc;
                    end
                end
                2'b01: begin
                    head_word <= tail_word;
                    head_pc   <= tail_pc;
                    count     <= count - CW'(1);
                end
                2'b10: begin
                    if (count == CW'(0)) begin
                        head_word <= imem_q;
                        head_pc   <= pc;
                    end else begin
                        tail_word <= imem_q;
                        tail_pc   <= pc;
                    end
                    count <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)    fetch_count <= 32'd0;
        else if (pop) fetch_count <= fetch_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl with a small behavioural instruction ROM.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [63:0] instr_pc;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.N(32), .RESET_PC(64'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_q         (imem_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc),
        .halted         (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    // Test program: known words at 0, 4, 0x24, 0x68, 0xFC; unique filler elsewhere
    function automatic logic [31:0] rom(input logic [5:0] a);
        case (a)
            6'd0:    rom = 32'h8b1f03e9;
            6'd1:    rom = 32'hcb1f03ea;
            6'd9:    rom = 32'h8b1f03e9;
            6'd26:   rom = 32'hb400001f;
            6'd63:   rom = 32'h00000000;
            default: rom = 32'h10000000 | 32'(a);
        endcase
    endfunction

    always_comb imem_q = rom(imem_addr);

    typedef struct {
        logic        rst;
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] eo;
        logic [63:0] ep;
        logic        eh;
        logic [5:0]  ea;
        logic        cd;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic rv, input logic [63:0] rpc,
                                input logic rdy, input logic ev, input logic [31:0] eo,
                                input logic [63:0] ep, input logic eh, input logic [5:0] ea,
                                input logic cd);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev;
        v.eo = eo; v.ep = ep; v.eh = eh; v.ea = ea; v.cd = cd;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
        end
    endtask

    localparam int NV = 28;
    vec_t vecs[NV];

    initial begin
        int seen;
        //                 rst rv  rpc         rdy ev  out           pc         halt addr chk
        vecs[0]  = mk(1, 0, 64'h0,  0, 0, 32'h0,        64'h0,   0, 6'd0,  1);
        vecs[1]  = mk(1, 0, 64'h0,  0, 0, 32'h0,        64'h0,   0, 6'd0,  1);
        vecs[2]  = mk(0, 0, 64'h0,  0, 1, 32'h8b1f03e9, 64'h0,   0, 6'd1,  1);
        vecs[3]  = mk(0, 0, 64'h0,  0, 1, 32'h8b1f03e9, 64'h0,   0, 6'd2,  1);
        vecs[4]  = mk(0, 0, 64'h0,  0, 1, 32'h8b1f03e9, 64'h0,   0, 6'd2,  1);
        vecs[5]  = mk(0, 0, 64'h0,  0, 1, 32'h8b1f03e9, 64'h0,   0, 6'd2,  1);
        vecs[6]  = mk(0, 0, 64'h0,  0, 1, 32'h8b1f03e9, 64'h0,   0, 6'd2,  1);
        vecs[7]  = mk(0, 0, 64'h0,  1, 1, 32'hcb1f03ea, 64'h4,   0, 6'd3,  1);
        vecs[8]  = mk(0, 0, 64'h0,  1, 1, 32'h10000002, 64'h8,   0, 6'd4,  1);
        vecs[9]  = mk(0, 0, 64'h0,  0, 1, 32'h10000002, 64'h8,   0, 6'd4,  1);
        vecs[10] = mk(0, 1, 64'h24, 1, 0, 32'h0,        64'h0,   0, 6'd9,  0);
        vecs[11] = mk(0, 0, 64'h0,  0, 1, 32'h8b1f03e9, 64'h24,  0, 6'd10, 1);
        vecs[12] = mk(0, 1, 64'h6b, 0, 0, 32'h0,        64'h0,   0, 6'd26, 0);
        vecs[13] = mk(0, 0, 64'h0,  0, 1, 32'hb400001f, 64'h68,  1, 6'd27, 1);
        vecs[14] = mk(0, 0, 64'h0,  0, 1, 32'hb400001f, 64'h68,  1, 6'd27, 1);
        vecs[15] = mk(0, 0, 64'h0,  1, 0, 32'h0,        64'h0,   1, 6'd27, 0);
        vecs[16] = mk(0, 0, 64'h0,  1, 0, 32'h0,        64'h0,   1, 6'd27, 0);
        vecs[17] = mk(0, 1, 64'h0,  1, 0, 32'h0,        64'h0,   0, 6'd0,  0);
        vecs[18] = mk(0, 0, 64'h0,  1, 1, 32'h8b1f03e9, 64'h0,   0, 6'd1,  1);
        vecs[19] = mk(0, 1, 64'hfc, 1, 0, 32'h0,        64'h0,   0, 6'd63, 0);
        vecs[20] = mk(0, 0, 64'h0,  1, 1, 32'h00000000, 64'hfc,  0, 6'd0,  1);
        vecs[21] = mk(0, 0, 64'h0,  1, 1, 32'h8b1f03e9, 64'h100, 0, 6'd1,  1);
        vecs[22] = mk(0, 1, 64'h68, 0, 0, 32'h0,        64'h0,   0, 6'd26, 0);
        vecs[23] = mk(0, 0, 64'h0,  0, 1, 32'hb400001f, 64'h68,  1, 6'd27, 1);
        vecs[24] = mk(1, 1, 64'h24, 0, 0, 32'h0,        64'h0,   0, 6'd0,  1);
        vecs[25] = mk(0, 0, 64'h0,  1, 1, 32'h8b1f03e9, 64'h0,   0, 6'd1,  1);
        vecs[26] = mk(0, 0, 64'h0,  1, 1, 32'hcb1f03ea, 64'h4,   0, 6'd2,  1);
        vecs[27] = mk(0, 0, 64'h0,  1, 1, 32'h10000002, 64'h8,   0, 6'd3,  1);

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset          = vecs[i].rst;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            instr_ready    = vecs[i].rdy;
            @(posedge clk);
            #1;
            check("instr_valid", i, 64'(instr_valid), 64'(vecs[i].ev));
            check("halted",      i, 64'(halted),      64'(vecs[i].eh));
            check("imem_addr",   i, 64'(imem_addr),   64'(vecs[i].ea));
            if (vecs[i].ev || vecs[i].cd) begin
                check("instr_out", i, 64'(instr_out), 64'(vecs[i].eo));
                check("instr_pc",  i, instr_pc,       vecs[i].ep);
            end
        end

        // Redirect while streaming, then expect back-to-back delivery from 0x40
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 64'h40; instr_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 5 && seen == 0; c++) begin
            @(posedge clk);
            #1;
            if (instr_valid) seen = 1;
        end
        check("stream_start", 0, 64'(seen), 64'd1);
        if (seen == 1) begin
            for (int k = 0; k < 4; k++) begin
                check("stream_valid", k, 64'(instr_valid), 64'd1);
                check("stream_pc",    k, instr_pc, 64'h40 + 64'(4 * k));
                check("stream_out",   k, 64'(instr_out), 64'(32'h10000010 + 32'(k)));
                @(posedge clk);
                #1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
